alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; no other clock or reset port is permitted.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  request pulse, sampled only in IDLE.
REQ-005 OpIn  input  4  ALU op code for the request.
REQ-006 AIn  input  32  operand A.
REQ-007 BIn  input  32  operand B.
REQ-008 ShAmt  input  5  iteration count for shift/rotate ops, 0..31.
REQ-009 Busy  output  1  high while an operation is in progress (EXEC, ITER).
REQ-010 Done  output  1  one-cycle completion pulse.
REQ-011 Result  output  32  registered final result, held until the next completion or Reset.
REQ-012 ZeroOut  output  1  registered flag, high when Result == 0; computed internally, not taken from the ALU.
REQ-013 AluA, AluB  output  32 each  operands driven to the shared ALU.
REQ-014 AluOp  output  4  op code driven to the shared ALU.
REQ-015 AluOut  input  32  combinational ALU result.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, EXEC, ITER, DONE.
REQ-017 Shift ops SHALL be 1000 (arith right), 1001 (left), 1010 (logical right) and 1100 (rotate left); every other code is a single-pass op.
REQ-018 IDLE, Start=1 at edge k: latch OpIn/AIn/BIn/ShAmt; a working register W SHALL be loaded with AIn.
REQ-019 After edge k, the next state SHALL be ITER for a shift op with ShAmt>0, and EXEC otherwise.
REQ-020 EXEC SHALL drive AluA=A, AluB=B, AluOp=latched op for a single-pass op.
REQ-021 EXEC with a shift op and ShAmt=0 SHALL drive AluOp=0000 and AluB=0, so that Result=A.
REQ-022 At edge k+1, EXEC SHALL capture AluOut into Result and go to DONE.
REQ-023 In ITER, each cycle SHALL drive AluA=W, AluB=B, AluOp=latched op, load W<=AluOut and decrement an iteration counter.
REQ-024 ITER SHALL run exactly ShAmt cycles; at the last edge (k+ShAmt), AluOut SHALL be captured into Result and the FSM SHALL go to DONE.
REQ-025 DONE SHALL assert Done for exactly one cycle, update ZeroOut with Result, and return to IDLE at the next edge; Busy=0 in DONE.
REQ-026 Latency from the Start edge to Done high: 1 cycle for single-pass ops and ShAmt=0; ShAmt cycles for shifts with ShAmt>0.
REQ-027 Start SHALL be ignored in EXEC, ITER and DONE; inputs changing after edge k SHALL NOT affect the operation in flight.
REQ-028 Undefined op codes SHALL be passed to the ALU unchanged as single-pass ops.
REQ-029 In IDLE and DONE, the ALU-side outputs SHALL hold their last values (no requirement on value).

Reset
REQ-030 While Reset=1, independent of Clk: state=IDLE; Busy=0, Done=0, Result=0, ZeroOut=1, W=0, counter=0, AluA=0, AluB=0, AluOp=0000.
REQ-031 Reset asserted mid-operation SHALL abort the operation with no Done pulse; Result returns to 0.
REQ-032 Start SHALL first be accepted at the first rising edge after Reset deasserts.

Verification
REQ-033 Op=0000, A=5, B=7, Start -> Busy for 1 cycle, then Done for 1 cycle, Result=12, ZeroOut=0.
REQ-034 Op=0001, A=9, B=9 -> Result=0, ZeroOut=1, Done 1 cycle after Start.
REQ-035 Op=1100, A=0x80000001, ShAmt=4 -> Busy for 4 cycles, Result=0x00000018, one Done pulse.
REQ-036 Op=1000, A=0x80000000, ShAmt=31 -> Result=0xFFFFFFFF; Op=1001, ShAmt=0, A=0x1234 -> Result=0x1234 after 1 cycle.
REQ-037 Start re-pulsed during ITER with different operands -> ignored, original Result correct; Reset asserted in ITER cycle 2 -> Busy=0, Result=0, no Done.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - sequencer driving a shared external ALU for single-pass and iterated shift ops
module alu_seq_ctrl (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [3:0]  OpIn,
  input  logic [31:0] AIn,
  input  logic [31:0] BIn,
  input  logic [4:0]  ShAmt,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Result,
  output logic        ZeroOut,
  output logic [31:0] AluA,
  output logic [31:0] AluB,
  output logic [3:0]  AluOp,
  input  logic [31:0] AluOut
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] w_q, w_d;          // working register, also the ALU A operand
  logic [31:0] b_q, b_d;          // effective B operand for the op in flight
  logic [3:0]  op_q, op_d;        // effective op code for the op in flight
  logic [4:0]  cnt_q, cnt_d;      // remaining iterations
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == 4'b1000) || (op == 4'b1001) || (op == 4'b1010) || (op == 4'b1100);
  endfunction

  // State and datapath registers; reset clears everything and leaves ZeroOut high to match Result=0
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      w_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  // Next-state and datapath update; everything holds unless a state explicitly changes it
  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          w_d   = AIn;
          cnt_d = ShAmt;
          if (is_shift(OpIn) && (ShAmt != 5'd0)) begin
            op_d    = OpIn;
            b_d     = BIn;
            state_d = S_ITER;
          end else if (is_shift(OpIn)) begin
            // zero-length shift: ask the ALU for A + 0 so the result is A unchanged
            op_d    = 4'b0000;
            b_d     = '0;
            state_d = S_EXEC;
          end else begin
            op_d    = OpIn;
            b_d     = BIn;
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        result_d = AluOut;
        zero_d   = (AluOut == 32'd0);
        state_d  = S_DONE;
      end
      S_ITER: begin
        w_d   = AluOut;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          result_d = AluOut;
          zero_d   = (AluOut == 32'd0);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign Busy    = (state_q == S_EXEC) || (state_q == S_ITER);
  assign Done    = (state_q == S_DONE);
  assign Result  = result_q;
  assign ZeroOut = zero_q;
  assign AluA    = w_q;
  assign AluB    = b_q;
  assign AluOp   = op_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - self-checking bench for alu_seq_ctrl with a behavioural ALU and reference model
module tb_alu_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  op_in;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [4:0]  sh_amt;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero_out;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_out;

  int checks = 0;
  int errors = 0;

  alu_seq_ctrl dut (
    .Clk     (clk),
    .Reset   (rst),
    .Start   (start),
    .OpIn    (op_in),
    .AIn     (a_in),
    .BIn     (b_in),
    .ShAmt   (sh_amt),
    .Busy    (busy),
    .Done    (done),
    .Result  (result),
    .ZeroOut (zero_out),
    .AluA    (alu_a),
    .AluB    (alu_b),
    .AluOp   (alu_op),
    .AluOut  (alu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: shift ops move one bit per pass
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a & b;
      4'b0011: return a | b;
      4'b0100: return a ^ b;
      4'b1000: return {a[31], a[31:1]};
      4'b1001: return {a[30:0], 1'b0};
      4'b1010: return {1'b0, a[31:1]};
      4'b1100: return {a[30:0], a[31]};
      default: return a + (b ^ {28'd0, op});
    endcase
  endfunction

  assign alu_out = alu_f(alu_a, alu_b, alu_op);

  function automatic bit shift_op(input logic [3:0] op);
    return (op == 4'd8) || (op == 4'd9) || (op == 4'd10) || (op == 4'd12);
  endfunction

  // Reference result: whole shift of n positions in one step
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input int n);
    if (!shift_op(op)) return alu_f(a, b, op);
    if (n == 0) return a;
    case (op)
      4'd8:    return 32'($signed(a) >>> n);
      4'd9:    return a << n;
      4'd10:   return a >> n;
      default: return (a << n) | (a >> (32 - n));
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input bit pester);
    logic [31:0] exp_res;
    int          lat;
    int          busy_cnt;
    int          done_cnt;
    bit          first;
    bit          zero_len;
    exp_res  = ref_result(op, a, b, int'(sh));
    zero_len = shift_op(op) && (sh == 5'd0);
    lat      = (shift_op(op) && sh != 5'd0) ? int'(sh) : 1;
    @(negedge clk);
    op_in = op; a_in = a; b_in = b; sh_amt = sh; start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    op_in  = 4'($urandom);
    a_in   = $urandom;
    b_in   = $urandom;
    sh_amt = 5'($urandom);
    busy_cnt = 0;
    done_cnt = 0;
    first    = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (first) begin
        chk("alu_a_first", alu_a, a);
        chk("alu_op_first", {28'd0, alu_op}, zero_len ? 32'd0 : {28'd0, op});
        chk("alu_b_first", alu_b, zero_len ? 32'd0 : b);
        first = 1'b0;
      end
      if (done) begin
        done_cnt++;
        start = 1'b0;
        chk("result", result, exp_res);
        chk("zero_out", {31'd0, zero_out}, {31'd0, exp_res == 32'd0});
        chk("busy_in_done", {31'd0, busy}, 32'd0);
        break;
      end
      if (busy) busy_cnt++;
      else break;
      if (pester) begin
        start  = 1'b1;
        op_in  = 4'($urandom);
        a_in   = $urandom;
        b_in   = $urandom;
        sh_amt = 5'($urandom);
      end
    end
    start = 1'b0;
    chk("latency", busy_cnt, lat);
    chk("done_seen", done_cnt, 1);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("result_held", result, exp_res);
  endtask

  initial begin
    int done_cnt;
    logic [3:0] rop;
    rst = 1'b1; start = 1'b0; op_in = '0; a_in = '0; b_in = '0; sh_amt = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero_out}, 32'd1);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
    rst = 1'b0;

    run_op(4'b0000, 32'd5, 32'd7, 5'd0, 1'b0);
    run_op(4'b0001, 32'd9, 32'd9, 5'd0, 1'b0);
    run_op(4'b1100, 32'h8000_0001, 32'd0, 5'd4, 1'b0);
    chk("rotate_example", result, 32'h0000_0018);
    run_op(4'b1000, 32'h8000_0000, 32'd3, 5'd31, 1'b0);
    chk("asr31_example", result, 32'hFFFF_FFFF);
    run_op(4'b1001, 32'h0000_1234, 32'd55, 5'd0, 1'b0);
    chk("shift0_example", result, 32'h0000_1234);
    run_op(4'b1111, 32'h0F0F_0000, 32'h0000_00F0, 5'd3, 1'b0);
    run_op(4'b1100, 32'h8000_0001, 32'd1, 5'd4, 1'b1);
    chk("pester_rotate", result, 32'h0000_0018);

    // Reset during the second ITER cycle aborts the operation
    @(negedge clk);
    op_in = 4'b1100; a_in = 32'hDEAD_BEEF; b_in = 32'd0; sh_amt = 5'd8; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_zero", {31'd0, zero_out}, 32'd1);
    chk("abort_alu_b", alu_b, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 3))
          0: rop = 4'd8;
          1: rop = 4'd9;
          2: rop = 4'd10;
          default: rop = 4'd12;
        endcase
      end else begin
        rop = 4'($urandom);
      end
      run_op(rop, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
             ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
